kmkz_rf_warb: RTL and testbench
===============================

KMKZ_RF_WARB -- requirements
Module: kmkz_rf_warb

Interface
REQ-001 SHALL have parameter INIT_ZERO, default 1, meaning: zero-fill x1..x31 after reset.
REQ-002 SHALL have parameter DBG_EN, default 1, meaning: debug write port present; when 0, dbg_ack_o tied 0.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wb_we_i in 1, wb_rd_i in 5, wb_value_i in 32: pipeline writeback request.
REQ-006 SHALL have ports lu_issue_i in 1, lu_issue_rd_i in 5: long-latency op (mul/div/load) issued, destination register.
REQ-007 SHALL have ports lu_valid_i in 1, lu_rd_i in 5, lu_value_i in 32, lu_ready_o out 1: long-latency result handshake.
REQ-008 SHALL have ports dbg_req_i in 1, dbg_addr_i in 5, dbg_wdata_i in 32, dbg_ack_o out 1: debug register write.
REQ-009 SHALL have ports d_valid_i in 1, d_rs1_i in 5, d_rs2_i in 5, d_rd_i in 5, hazard_stall_o out 1: decode hazard check.
REQ-010 SHALL have ports rf_we_o out 1, rf_rd_o out 5, rf_value_o out 32: shared register-file write port.
REQ-011 SHALL have port init_done_o out 1: high once state RUN reached.

Function
REQ-012 SHALL implement FSM states INIT, RUN; reset enters INIT if INIT_ZERO=1, else RUN.
REQ-013 INIT: 5-bit counter starts at 1; each cycle rf_we_o=1, rf_rd_o=counter, rf_value_o=0; counter increments; after writing 31, next state RUN (exactly 31 INIT cycles).
REQ-014 INIT: lu_ready_o=0, dbg_ack_o=0, hazard_stall_o=1, wb_we_i ignored.
REQ-015 RUN: write-port grant fixed priority wb > lu > dbg, decided combinationally in the same cycle; rf_* outputs combinational from granted source.
REQ-016 lu_ready_o SHALL equal (state==RUN && !wb_we_i); lu transfer occurs when lu_valid_i && lu_ready_o.
REQ-017 dbg_ack_o SHALL be one-cycle combinational grant: (state==RUN && dbg_req_i && !wb_we_i && !lu_valid_i && DBG_EN); requester holds request until ack.
REQ-018 Any granted write with address 0 SHALL drive rf_we_o=0 but still complete its handshake (ready/ack asserted).
REQ-019 No grant in RUN: rf_we_o=0, rf_rd_o=0, rf_value_o=0.
REQ-020 SHALL keep 32-bit pending mask; bit 0 always 0; lu_issue_i sets bit lu_issue_rd_i; lu transfer clears bit lu_rd_i.
REQ-021 Issue and completion to the same register in the same cycle: bit remains set (issue wins).
REQ-022 Completion to a non-pending register: write still performed, mask unchanged.
REQ-023 RUN: hazard_stall_o = d_valid_i && (pending[d_rs1_i] || pending[d_rs2_i] || pending[d_rd_i]), combinational.
REQ-024 lu_issue_i in INIT SHALL be ignored.

Reset
REQ-025 On rst_i assertion, asynchronously: state=INIT (or RUN per INIT_ZERO), counter=1, pending=0, init_done_o=0 (1 if INIT_ZERO=0).
REQ-026 Reset mid-INIT or mid-RUN SHALL abandon all in-flight requests and restart the INIT sequence from x1.
REQ-027 While rst_i high: rf_we_o=0, lu_ready_o=0, dbg_ack_o=0, hazard_stall_o=1.

Verification
REQ-028 Release reset, INIT_ZERO=1 -> 31 consecutive writes x1..x31 value 0, init_done_o rises on cycle 32, stall drops.
REQ-029 RUN, wb_we_i=1 rd=5 val=0xDEADBEEF with lu_valid_i=1 rd=6 -> rf writes x5, lu_ready_o=0; next cycle wb idle -> x6 written, lu_ready_o=1.
REQ-030 lu_issue_i rd=7, then decode rs2=7 -> hazard_stall_o=1 until lu completes rd=7; stall drops the cycle after transfer.
REQ-031 dbg_req_i addr=0 data=0x1234 -> dbg_ack_o=1, rf_we_o=0; addr=3 -> x3=0x1234 written on ack cycle.
REQ-032 Same-cycle lu_issue_i rd=9 and lu completion rd=9 -> pending[9] stays 1, decode rs1=9 stalls.
REQ-033 Assert rst_i at INIT counter=17 -> outputs reset immediately; after release INIT restarts at x1.

Source files
------------

// File: rtl/kmkz_rf_warb.sv
// kmkz_rf_warb: register-file write-port arbiter with post-reset zero-fill and long-latency hazard tracking
module kmkz_rf_warb #(
  parameter bit INIT_ZERO = 1'b1,
  parameter bit DBG_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_value_i,
  input  logic        lu_issue_i,
  input  logic [4:0]  lu_issue_rd_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_value_i,
  output logic        lu_ready_o,
  input  logic        dbg_req_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  input  logic        d_valid_i,
  input  logic [4:0]  d_rs1_i,
  input  logic [4:0]  d_rs2_i,
  input  logic [4:0]  d_rd_i,
  output logic        hazard_stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_value_o,
  output logic        init_done_o
);
  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RST_STATE = INIT_ZERO ? INIT : RUN;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        run, init, wb_g, lu_g, any_g;
  logic [4:0]  g_rd;
  logic [31:0] g_val;
  // Grant the shared write port (wb > lu > dbg) and drive handshakes, held quiet during reset
  always_comb begin
    run            = state_q == RUN && !rst_i;
    init           = state_q == INIT && !rst_i;
    wb_g           = run && wb_we_i;
    lu_ready_o     = run && !wb_we_i;
    lu_g           = lu_ready_o && lu_valid_i;
    dbg_ack_o      = DBG_EN && run && dbg_req_i && !wb_we_i && !lu_valid_i;
    any_g          = wb_g || lu_g || dbg_ack_o;
    g_rd           = wb_g ? wb_rd_i : lu_g ? lu_rd_i : dbg_ack_o ? dbg_addr_i : 5'd0;
    g_val          = wb_g ? wb_value_i : lu_g ? lu_value_i : dbg_ack_o ? dbg_wdata_i : 32'd0;
    rf_we_o        = init || (any_g && g_rd != 5'd0);
    rf_rd_o        = init ? cnt_q : run ? g_rd : 5'd0;
    rf_value_o     = run ? g_val : 32'd0;
    hazard_stall_o = !run || (d_valid_i && (pend_q[d_rs1_i] || pend_q[d_rs2_i] || pend_q[d_rd_i]));
    init_done_o    = state_q == RUN;
  end
  // Next state: zero-fill sweep, then pending-mask upkeep where issue beats completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? RUN : INIT;
    end
    if (lu_g) pend_d[lu_rd_i] = 1'b0;
    if (run && lu_issue_i) pend_d[lu_issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= 5'd1;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_kmkz_rf_warb.sv
// tb_kmkz_rf_warb: randomized scoreboard bench against a behavioural arbiter model
module tb_kmkz_rf_warb;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic wb_we_i = 0, lu_issue_i = 0, lu_valid_i = 0, dbg_req_i = 0, d_valid_i = 0;
  logic [4:0] wb_rd_i = 0, lu_issue_rd_i = 0, lu_rd_i = 0, dbg_addr_i = 0, d_rs1_i = 0, d_rs2_i = 0, d_rd_i = 0;
  logic [31:0] wb_value_i = 0, lu_value_i = 0, dbg_wdata_i = 0;
  logic lu_ready_o, dbg_ack_o, hazard_stall_o, rf_we_o, init_done_o;
  logic [4:0] rf_rd_o;
  logic [31:0] rf_value_o;
  typedef struct {logic dv, we, rdy, ack, stall, done; logic [4:0] rd; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int init_next = 1;
  bit pend[32];
  always #5 clk_i = ~clk_i;
  kmkz_rf_warb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_value_i(wb_value_i),
    .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
    .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_value_i(lu_value_i), .lu_ready_o(lu_ready_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o),
    .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i), .hazard_stall_o(hazard_stall_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_value_o(rf_value_o), .init_done_o(init_done_o)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask
  // Model the cycle from the current inputs, queue the expectation, then advance one clock
  task automatic tick(bit pulse = 0);
    exp_t e;
    bit granted;
    e = '{default: '0};
    e.dv = 1;
    e.stall = 1;
    if (rst_i) begin
      e.dv = 0;
      init_next = pulse ? 2 : 1;
      foreach (pend[i]) pend[i] = 0;
    end else if (init_next != 0) begin
      e.we = 1;
      e.rd = 5'(init_next);
      init_next = init_next == 31 ? 0 : init_next + 1;
    end else begin
      e.done = 1;
      e.stall = d_valid_i && (pend[d_rs1_i] || pend[d_rs2_i] || pend[d_rd_i]);
      e.rdy = !wb_we_i;
      granted = 1;
      if (wb_we_i) begin e.rd = wb_rd_i; e.val = wb_value_i; end
      else if (lu_valid_i) begin e.rd = lu_rd_i; e.val = lu_value_i; end
      else if (dbg_req_i) begin e.ack = 1; e.rd = dbg_addr_i; e.val = dbg_wdata_i; end
      else granted = 0;
      e.we = granted && e.rd != 0;
      e.dv = !granted || e.rd != 0;
      if (!wb_we_i && lu_valid_i) pend[lu_rd_i] = 0;
      if (lu_issue_i) pend[lu_issue_rd_i] = 1;
      pend[0] = 0;
    end
    sb.push_back(e);
    if (pulse) begin
      @(negedge clk_i);
      #1 rst_i = 0;
      #1 chk("restart_x1", rf_rd_o, 5'd1);
    end
    @(posedge clk_i);
    #1;
  endtask
  // Monitor: compare every presented cycle against the oldest queued expectation
  always @(negedge clk_i) if (sb.size() != 0) begin : mon
    exp_t e;
    e = sb.pop_front();
    chk("rf_we", rf_we_o, e.we);
    chk("lu_ready", lu_ready_o, e.rdy);
    chk("dbg_ack", dbg_ack_o, e.ack);
    chk("stall", hazard_stall_o, e.stall);
    chk("init_done", init_done_o, e.done);
    if (e.dv) begin
      chk("rf_rd", rf_rd_o, e.rd);
      chk("rf_value", rf_value_o, e.val);
    end
  end
  initial begin
    @(posedge clk_i);
    #1;
    tick();
    tick();
    rst_i = 0;
    repeat (32) tick();
    wb_we_i = 1; wb_rd_i = 5; wb_value_i = 32'hDEADBEEF;
    lu_valid_i = 1; lu_rd_i = 6; lu_value_i = 32'h0BADF00D;
    tick();
    wb_we_i = 0;
    tick();
    lu_valid_i = 0;
    lu_issue_i = 1; lu_issue_rd_i = 7;
    tick();
    lu_issue_i = 0; d_valid_i = 1; d_rs2_i = 7;
    tick();
    tick();
    lu_valid_i = 1; lu_rd_i = 7; lu_value_i = 32'h77;
    tick();
    lu_valid_i = 0;
    tick();
    d_valid_i = 0; d_rs2_i = 0;
    dbg_req_i = 1; dbg_addr_i = 0; dbg_wdata_i = 32'h1234;
    tick();
    dbg_addr_i = 3;
    tick();
    dbg_req_i = 0;
    lu_issue_i = 1; lu_issue_rd_i = 9; lu_valid_i = 1; lu_rd_i = 9; lu_value_i = 32'h99;
    tick();
    lu_issue_i = 0; lu_valid_i = 0; d_valid_i = 1; d_rs1_i = 9;
    tick();
    d_valid_i = 0; d_rs1_i = 0;
    repeat (500) begin
      rst_i = $urandom_range(0, 249) == 0;
      wb_we_i = $urandom_range(0, 2) == 0; wb_rd_i = 5'($urandom); wb_value_i = $urandom;
      lu_issue_i = $urandom_range(0, 2) == 0; lu_issue_rd_i = 5'($urandom_range(0, 11));
      lu_valid_i = $urandom_range(0, 1) == 0; lu_rd_i = 5'($urandom_range(0, 11)); lu_value_i = $urandom;
      dbg_req_i = $urandom_range(0, 1) == 0; dbg_addr_i = 5'($urandom); dbg_wdata_i = $urandom;
      d_valid_i = $urandom_range(0, 1) == 0;
      d_rs1_i = 5'($urandom_range(0, 11)); d_rs2_i = 5'($urandom_range(0, 11)); d_rd_i = 5'($urandom_range(0, 11));
      tick();
    end
    {wb_we_i, lu_issue_i, lu_valid_i, dbg_req_i, d_valid_i} = '0;
    rst_i = 1;
    tick();
    rst_i = 0;
    repeat (16) tick();
    rst_i = 1;
    tick(1);
    repeat (40) tick();
    @(negedge clk_i);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
